// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with level flags and optional FWFT
module sync_fifo_param #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              full_r;
    logic              empty_r;
    logic              af_r;
    logic              ae_r;
    logic              ovf_r;
    logic              unf_r;
    logic              rd_acc;
    logic              wr_acc;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc   = bus.rd_en & ~empty_r;
        wr_acc   = bus.wr_en & (~full_r | rd_acc);
        cnt_next = cnt;
        if (wr_acc && !rd_acc) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + ADDR_W'(1);
            end
            cnt     <= cnt_next;
            full_r  <= (cnt_next == CNT_W'(DEPTH));
            empty_r <= (cnt_next == '0);
            af_r    <= (cnt_next >= CNT_W'(AF_LEVEL));
            ae_r    <= (cnt_next <= CNT_W'(AE_LEVEL));
        end
    end

    // Storage is deliberately left uncleared; only pointers define its contents.
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && wr_acc) begin
            mem[wptr] <= bus.wr_data;
        end
    end

    // Sticky errors survive flush; a new error in the clr_err cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (bus.flush) begin
            if (bus.clr_err) begin
                ovf_r <= 1'b0;
                unf_r <= 1'b0;
            end
        end else begin
            ovf_r <= (ovf_r & ~bus.clr_err) | (bus.wr_en & ~wr_acc);
            unf_r <= (unf_r & ~bus.clr_err) | (bus.rd_en & ~rd_acc);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rd_data  = empty_r ? '0 : mem[rptr];
            assign bus.rd_valid = ~empty_r;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_r;
            logic             rd_valid_r;

            always_ff @(posedge clk) begin
                if (reset || bus.flush) begin
                    rd_data_r  <= '0;
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_valid_r <= rd_acc;
                    if (rd_acc) begin
                        rd_data_r <= mem[rptr];
                    end
                end
            end

            assign bus.rd_data  = rd_data_r;
            assign bus.rd_valid = rd_valid_r;
        end
    endgenerate

    assign bus.count        = cnt;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = af_r;
    assign bus.almost_empty = ae_r;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = unf_r;
endmodule
